multi_ema_trader: RTL

MULTI_EMA_TRADER -- requirements
Module: multi_ema_trader

---
 rtl/multi_ema_trader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/multi_ema_trader.sv
// Per-symbol dual-EMA crossover trader: fixed-point EMAs, warmup gating,
// position limits and a show-ahead output queue with drop counting.
module multi_ema_trader #(
    parameter int PRICE_W    = 16,
    parameter int NUM_SYM    = 4,
    parameter int SHORT_SH   = 3,
    parameter int LONG_SH    = 6,
    parameter int WARMUP     = 200,
    parameter int THRESH     = 65536,
    parameter int QTY        = 50,
    parameter int POS_LIM    = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int SYM_W     = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PRICE_W-1:0]      price_in,
    input  logic [SYM_W-1:0]        sym_in,
    input  logic                    price_valid,
    input  logic                    enable,
    output logic [16+PRICE_W-1:0]   trade_word,
    output logic [SYM_W-1:0]        trade_sym,
    output logic                    trade_valid,
    input  logic                    trade_ready,
    output logic [15:0]             drop_cnt
);

    localparam int EW     = PRICE_W + 17;
    localparam int CNT_W  = $clog2(WARMUP + 2);
    localparam int POS_W  = $clog2(POS_LIM + 1) + 2;
    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WORD_W = 16 + PRICE_W;
    localparam int ENT_W  = SYM_W + WORD_W;

    localparam logic signed [EW-1:0]    THR_P     = EW'(THRESH);
    localparam logic signed [EW-1:0]    THR_N     = -THR_P;
    localparam logic signed [POS_W-1:0] POS_MAX   = POS_W'(POS_LIM);
    localparam logic signed [POS_W-1:0] POS_MIN   = -POS_MAX;
    localparam logic signed [POS_W-1:0] POS_ONE   = POS_W'(1);
    localparam logic [CNT_W-1:0]        CNT_MAX   = CNT_W'(WARMUP);
    localparam logic [SYM_W:0]          SYM_LIM   = (SYM_W + 1)'(NUM_SYM);
    localparam logic [AW:0]             FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW-1:0]           PTR_LAST  = AW'(FIFO_DEPTH - 1);
    localparam logic [14:0]             QTY_F     = 15'(QTY);

    logic signed [EW-1:0]    ema_s_r [NUM_SYM];
    logic signed [EW-1:0]    ema_l_r [NUM_SYM];
    logic signed [EW-1:0]    diff_r  [NUM_SYM];
    logic [CNT_W-1:0]        cnt_r   [NUM_SYM];
    logic signed [POS_W-1:0] pos_r   [NUM_SYM];

    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      fifo_cnt;
    logic [15:0]      drop_cnt_r;

    logic                    sample, seed, warm;
    logic signed [EW-1:0]    p_ext, cur_s, cur_l, cur_d, dlt_s, dlt_l, ns, nl, nd;
    logic signed [POS_W-1:0] pos_cur;
    logic                    buy_c, sell_c, issue_buy, issue_sell, issue;
    logic                    fifo_full, pop, push, drop;
    logic [ENT_W-1:0]        new_ent, head;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Candidate evaluation uses the selected symbol's pre-edge state, so
    // consecutive samples on one symbol always chain through stored values.
    always_comb begin
        sample  = price_valid && ({1'b0, sym_in} < SYM_LIM);
        p_ext   = {1'b0, price_in, 16'b0};
        cur_s   = ema_s_r[sym_in];
        cur_l   = ema_l_r[sym_in];
        cur_d   = diff_r[sym_in];
        pos_cur = pos_r[sym_in];
        seed    = (cnt_r[sym_in] == '0);
        warm    = (cnt_r[sym_in] >= CNT_MAX);
        dlt_s   = p_ext - cur_s;
        dlt_l   = p_ext - cur_l;
        ns      = cur_s + (dlt_s >>> SHORT_SH);
        nl      = cur_l + (dlt_l >>> LONG_SH);
        nd      = ns - nl;
        buy_c   = !seed && (cur_d < THR_P) && (nd >= THR_P);
        sell_c  = !seed && (cur_d > THR_N) && (nd <= THR_N);
        issue_buy  = sample && warm && enable && buy_c  && (pos_cur < POS_MAX);
        issue_sell = sample && warm && enable && sell_c && (pos_cur > POS_MIN);
        issue   = issue_buy || issue_sell;
        new_ent = {sym_in, issue_buy, QTY_F, price_in};
    end

    assign trade_valid = (fifo_cnt != '0);
    assign fifo_full   = (fifo_cnt == FIFO_FULL);
    assign pop         = trade_valid && trade_ready;
    assign push        = issue && (!fifo_full || pop);
    assign drop        = issue && fifo_full && !pop;
    assign head        = fifo_mem[rd_ptr];
    assign trade_word  = trade_valid ? head[WORD_W-1:0] : '0;
    assign trade_sym   = trade_valid ? head[ENT_W-1 -: SYM_W] : '0;
    assign drop_cnt    = drop_cnt_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                ema_s_r[i] <= '0;
                ema_l_r[i] <= '0;
                diff_r[i]  <= '0;
                cnt_r[i]   <= '0;
                pos_r[i]   <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            drop_cnt_r <= '0;
        end else begin
            if (sample) begin
                if (seed) begin
                    ema_s_r[sym_in] <= p_ext;
                    ema_l_r[sym_in] <= p_ext;
                    diff_r[sym_in]  <= '0;
                end else begin
                    ema_s_r[sym_in] <= ns;
                    ema_l_r[sym_in] <= nl;
                    diff_r[sym_in]  <= nd;
                end
                if (!warm) begin
                    cnt_r[sym_in] <= cnt_r[sym_in] + 1'b1;
                end
                if (push) begin
                    pos_r[sym_in] <= issue_buy ? pos_cur + POS_ONE : pos_cur - POS_ONE;
                end
            end
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (drop && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
        end
    end

    // Storage needs no reset: the occupancy count alone defines valid entries.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[wr_ptr] <= new_ent;
        end
    end

endmodule
